// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: the owner keeps the grant for up to its weight
// in cycles, then the grant rotates. All outputs are registered.
module wrr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int WEIGHT_W  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req_i,
   input  logic [NUM_PORTS*WEIGHT_W-1:0]   weight_i,
   output logic [NUM_PORTS-1:0]            gnt_o,
   output logic [$clog2(NUM_PORTS)-1:0]    gnt_id_o,
   output logic                            gnt_valid_o
);
   localparam int IDX_W = $clog2(NUM_PORTS);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     owner_q, ptr_q;
   logic [WEIGHT_W-1:0]  credit_q;
   logic [NUM_PORTS-1:0] gnt_q;
   logic [IDX_W-1:0]     gnt_id_q;
   logic                 gnt_valid_q;

   logic [IDX_W-1:0]     start, pick, owner_inc;
   logic                 found, keep;
   logic [WEIGHT_W-1:0]  wsel, credit_d;
   int unsigned          idx;

   assign owner_inc = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

   // Search order: from ptr when idle, from owner+1 when rotating; the owner
   // itself is visited last so a lone requester is re-granted without a bubble.
   always_comb begin
      start = (state_q == IDLE) ? ptr_q : owner_inc;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = (int'(start) + k) % NUM_PORTS;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   // Weight of zero behaves as one, i.e. a freshly loaded credit of zero.
   assign wsel     = weight_i[pick*WEIGHT_W +: WEIGHT_W];
   assign credit_d = (wsel == '0) ? '0 : wsel - 1'b1;
   assign keep     = req_i[owner_q] && (credit_q != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         credit_q    <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q     <= GRANT;
                  owner_q     <= pick;
                  credit_q    <= credit_d;
                  gnt_q       <= NUM_PORTS'(1) << pick;
                  gnt_id_q    <= pick;
                  gnt_valid_q <= 1'b1;
               end
            end
            GRANT: begin
               if (keep) begin
                  credit_q <= credit_q - 1'b1;
               end else if (found) begin
                  owner_q     <= pick;
                  credit_q    <= credit_d;
                  gnt_q       <= NUM_PORTS'(1) << pick;
                  gnt_id_q    <= pick;
                  gnt_valid_q <= 1'b1;
               end else begin
                  state_q     <= IDLE;
                  ptr_q       <= owner_inc;
                  gnt_q       <= '0;
                  gnt_id_q    <= '0;
                  gnt_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign gnt_valid_o = gnt_valid_q;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (4 ports, 4-bit weights) with hand-computed
// grant sequences.
module tb_wrr_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] weight;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        gnt_valid;

   int errors = 0;
   int checks = 0;

   wrr_arbiter #(.NUM_PORTS(4), .WEIGHT_W(4)) dut (
      .clk(clk), .reset(reset), .req_i(req), .weight_i(weight),
      .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_valid_o(gnt_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks grant vector plus the derived id and valid outputs.
   task automatic check_gnt(input string tag, input logic [3:0] exp);
      logic [1:0] eid;
      eid = 2'd0;
      for (int i = 0; i < 4; i++) if (exp[i]) eid = 2'(i);
      check({tag, ".gnt"}, 32'(gnt), 32'(exp));
      check({tag, ".id"}, 32'(gnt_id), 32'(eid));
      check({tag, ".vld"}, 32'(gnt_valid), 32'(exp != 4'b0));
   endtask

   task automatic do_reset();
      req    = 4'b0;
      reset  = 1'b1;
      tick();
      tick();
      reset  = 1'b0;
   endtask

   logic [3:0] seq_rot [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] seq_w   [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                               4'b0001, 4'b0001, 4'b0001, 4'b0010};

   initial begin
      // Reset held with all ports requesting
      reset  = 1'b1;
      req    = 4'b1111;
      weight = 16'h1111;
      #1;
      check_gnt("rst_async", 4'b0000);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_gnt("rst_hold", 4'b0000);
      end
      reset = 1'b0;
      tick();
      check_gnt("rst_first", 4'b0001);

      // Equal weights rotate one cycle each
      do_reset();
      weight = 16'h1111;
      req    = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_gnt($sformatf("rot%0d", c), seq_rot[c]);
      end

      // Weight 3 on port 0, weight 1 on port 1
      do_reset();
      weight = 16'h0013;
      req    = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         tick();
         check_gnt($sformatf("wt%0d", c), seq_w[c]);
      end

      // Lone requester with zero weight keeps the grant every cycle
      do_reset();
      weight = 16'h0000;
      req    = 4'b0100;
      for (int c = 0; c < 6; c++) begin
         tick();
         check_gnt($sformatf("lone%0d", c), 4'b0100);
      end

      // Weight change mid-grant leaves the loaded credit alone
      do_reset();
      weight = 16'h0012;
      req    = 4'b0011;
      tick();
      check_gnt("wchg0", 4'b0001);
      weight = 16'h001f;
      tick();
      check_gnt("wchg1", 4'b0001);
      tick();
      check_gnt("wchg2", 4'b0010);

      // Early release, then idle, then resume from stored ptr (=2)
      do_reset();
      weight = 16'h0114;
      req    = 4'b0001;
      tick();
      check_gnt("early0", 4'b0001);
      req = 4'b0110;
      tick();
      check_gnt("early1", 4'b0010);
      req = 4'b0000;
      tick();
      check_gnt("early_idle", 4'b0000);
      tick();
      check_gnt("early_idle2", 4'b0000);
      req = 4'b0110;
      tick();
      check_gnt("early_resume", 4'b0100);

      // Reset asserted mid-grant clears outputs without a clock edge
      do_reset();
      weight = 16'h1111;
      req    = 4'b1000;
      tick();
      check_gnt("mid_pre", 4'b1000);
      #1 reset = 1'b1;
      #1;
      check_gnt("mid_async", 4'b0000);
      req = 4'b1010;
      tick();
      reset = 1'b0;
      tick();
      check_gnt("mid_first", 4'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter WEIGHT_W, default 4, giving the width of each per-port weight field.
REQ-003 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_i, input, NUM_PORTS: per-port request level; bit i is port i.
REQ-006 Port weight_i, input, NUM_PORTS*WEIGHT_W: per-port weight, carried in bits [i*WEIGHT_W +: WEIGHT_W] for port i.
REQ-007 Port gnt_o, output, NUM_PORTS: registered grant; one-hot or all-zero.
REQ-008 Port gnt_id_o, output, $clog2(NUM_PORTS): binary index of the granted port; 0 when no grant is active.
REQ-009 Port gnt_valid_o, output, 1: high when gnt_o is nonzero.

Function
REQ-010 The block SHALL hold this state: owner index, round-robin pointer ptr, credit counter of WEIGHT_W bits, and a two-state FSM (IDLE, GRANT).
REQ-011 The effective weight of port i SHALL be max(weight_i field, 1); a weight of 0 SHALL behave as 1.
REQ-012 gnt_o, gnt_id_o and gnt_valid_o SHALL be driven from flops; a request sampled on edge k SHALL appear as a grant after edge k, with no combinational path from req_i to gnt_o.
REQ-013 In the IDLE state, when any req_i bit is set, the block SHALL select the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_PORTS, then go to GRANT, set owner to the selected port, and load credit with (effective weight - 1).
REQ-014 In the IDLE state, when req_i is 0, the block SHALL stay in IDLE with gnt_o=0 and ptr unchanged.
REQ-015 In the GRANT state, when req_i[owner]=1 and credit>0, the block SHALL keep the owner and decrement credit by 1.
REQ-016 In the GRANT state, when req_i[owner]=0 or credit=0, the block SHALL search from owner+1 with wrap-around and grant the first requester with freshly loaded credit.
REQ-017 Under REQ-016, when no port requests, the block SHALL go to IDLE, drive gnt_o=0, and set ptr=owner+1 modulo NUM_PORTS.
REQ-018 When the owner is the only requester and its credit is exhausted, the search SHALL wrap back to the owner, which is re-granted with a freshly loaded credit and no bubble cycle.
REQ-019 Weight SHALL be sampled only when a grant is loaded; a change to weight_i during a grant SHALL NOT affect the current credit.
REQ-020 A port dropping its request SHALL lose the grant on the next edge, with no idle cycle when another port is requesting.
REQ-021 Over any window where all ports request continuously, port i SHALL receive exactly its effective weight of consecutive grant cycles per rotation, and no port SHALL be starved.
REQ-022 gnt_id_o SHALL always equal the index of the set bit of gnt_o, and gnt_valid_o SHALL equal |gnt_o in every cycle.

Reset
REQ-023 While reset=1, the block SHALL asynchronously force gnt_o=0, gnt_id_o=0, gnt_valid_o=0, ptr=0, owner=0, credit=0 and FSM=IDLE.
REQ-024 Assertion of reset during a grant SHALL clear the grant immediately, without waiting for a clock edge.
REQ-025 After reset deasserts, the first arbitration SHALL search from port 0.

Verification (NUM_PORTS=4, WEIGHT_W=4)
REQ-026 Reset scenario: assert reset with req_i=1111 -> gnt_o=0000 and gnt_valid_o=0 for the whole reset period; the first grant after release is 0001.
REQ-027 Equal-weight rotation scenario: all weights 1, req_i=1111 held -> gnt_o sequence 0001, 0010, 0100, 1000, 0001, with gnt_id_o sequence 0, 1, 2, 3, 0.
REQ-028 Weighted scenario: weight0=3, weight1=1, req_i=0011 held -> gnt_o sequence 0001, 0001, 0001, 0010, 0001, 0001, 0001, 0010.
REQ-029 Lone-requester and zero-weight scenario: req_i=0100 only, weight2=0 -> gnt_o=0100 on every cycle with no gaps, since weight 0 is treated as 1 and the owner is re-granted.
REQ-030 Early-release scenario: port0 granted with weight 4, then req_i changes to 0110 after 1 grant cycle -> next gnt_o=0010; after a later idle, arbitration resumes from the stored ptr.
REQ-031 Mid-grant reset scenario: assert reset while gnt_o=1000 -> gnt_o=0000 within the same cycle; after release with req_i=1010, the first grant is 0010.
